// File: rtl/decoder8b10b_pkg.sv
// Shared constants for the decoder8b10b receive path.
//   - Code-group synchronisation state encodings (also exported on o_state).
//   - Running-disparity encodings, shared with the code-group error checker.
package decoder8b10b_pkg;

  localparam logic [2:0] ST_LOSS_OF_SYNC = 3'd0;
  localparam logic [2:0] ST_COMMA_DET    = 3'd1;
  localparam logic [2:0] ST_ACQUIRE      = 3'd2;
  localparam logic [2:0] ST_SYNC_ACQ     = 3'd3;

  localparam logic RD_MINUS = 1'b0;
  localparam logic RD_PLUS  = 1'b1;

  typedef enum logic [2:0] {
    LOSS_OF_SYNC = ST_LOSS_OF_SYNC,
    COMMA_DET    = ST_COMMA_DET,
    ACQUIRE      = ST_ACQUIRE,
    SYNC_ACQ     = ST_SYNC_ACQ
  } sync_state_t;

endpackage

// File: rtl/rx_sync_monitor.sv
// rx_sync_monitor
//   Sits after the 8b/10b code-group error checker. It closes the running
//   disparity loop back to the checker, runs a comma-based code-group
//   synchronisation FSM and keeps a saturating invalid-CG count.
// Ports
//   i_clk, i_reset   : receive clock, synchronous active-high reset
//   i_valid          : code-group strobe qualifying all CG inputs
//   i_is_comma       : current CG is a comma
//   i_not_in_table   : checker not-in-table flag
//   i_disp_err       : checker disparity-error flag
//   i_run_disp_next  : checker running disparity after this CG (1 = RD+)
//   i_clr_cnt        : clear of o_err_cnt
//   o_run_disp       : registered running disparity, to the checker
//   o_sync           : code-group synchronisation achieved
//   o_cg_err         : one-cycle pulse, last accepted CG was invalid
//   o_err_cnt        : saturating count of invalid CGs
//   o_state          : FSM state, for debug
module rx_sync_monitor
  import decoder8b10b_pkg::*;
#(
  parameter int COMMAS_TO_SYNC  = 3,
  parameter int ERRS_TO_LOSE    = 4,
  parameter int GOOD_TO_RECOVER = 4,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_is_comma,
  input  logic                 i_not_in_table,
  input  logic                 i_disp_err,
  input  logic                 i_run_disp_next,
  input  logic                 i_clr_cnt,
  output logic                 o_run_disp,
  output logic                 o_sync,
  output logic                 o_cg_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [2:0]           o_state
);

  localparam logic [2:0] ACQ_LAST  = 3'(COMMAS_TO_SYNC - 1);
  localparam logic [2:0] LVL_LAST  = 3'(ERRS_TO_LOSE - 1);
  localparam logic [3:0] GOOD_LAST = 4'(GOOD_TO_RECOVER - 1);

  sync_state_t state, state_nxt;
  logic [2:0]  acq_cnt, acq_cnt_nxt;
  logic [2:0]  lvl, lvl_nxt;
  logic [3:0]  good, good_nxt;
  logic        bad;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  assign bad     = i_not_in_table | i_disp_err;
  assign o_state = state;

  always_comb begin
    state_nxt   = state;
    acq_cnt_nxt = acq_cnt;
    lvl_nxt     = lvl;
    good_nxt    = good;
    if (i_valid) begin
      case (state)
        LOSS_OF_SYNC: begin
          if (i_is_comma && !bad) begin
            if (COMMAS_TO_SYNC == 1) begin
              state_nxt = SYNC_ACQ;
              lvl_nxt   = '0;
              good_nxt  = '0;
            end else begin
              state_nxt   = COMMA_DET;
              acq_cnt_nxt = 3'd1;
            end
          end
        end
        COMMA_DET: begin
          if (bad || i_is_comma) state_nxt = LOSS_OF_SYNC;
          else                   state_nxt = ACQUIRE;
        end
        ACQUIRE: begin
          if (bad) begin
            state_nxt = LOSS_OF_SYNC;
          end else if (i_is_comma) begin
            if (acq_cnt == ACQ_LAST) begin
              state_nxt = SYNC_ACQ;
              lvl_nxt   = '0;
              good_nxt  = '0;
            end else begin
              state_nxt   = COMMA_DET;
              acq_cnt_nxt = acq_cnt + 3'd1;
            end
          end
        end
        SYNC_ACQ: begin
          // Commas count as ordinary valid CGs once synchronised.
          if (bad) begin
            good_nxt = '0;
            if (lvl == LVL_LAST) state_nxt = LOSS_OF_SYNC;
            else                 lvl_nxt   = lvl + 3'd1;
          end else if (lvl != 3'd0) begin
            if (good == GOOD_LAST) begin
              lvl_nxt  = lvl - 3'd1;
              good_nxt = '0;
            end else begin
              good_nxt = good + 4'd1;
            end
          end
        end
        default: state_nxt = LOSS_OF_SYNC;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= LOSS_OF_SYNC;
      acq_cnt    <= '0;
      lvl        <= '0;
      good       <= '0;
      o_sync     <= 1'b0;
      o_cg_err   <= 1'b0;
      o_err_cnt  <= '0;
      o_run_disp <= RD_MINUS;
    end else begin
      state    <= state_nxt;
      acq_cnt  <= acq_cnt_nxt;
      lvl      <= lvl_nxt;
      good     <= good_nxt;
      o_sync   <= (state_nxt == SYNC_ACQ);
      o_cg_err <= i_valid & bad;
      if (i_valid) o_run_disp <= i_run_disp_next;
      // Clear wins over increment; a bad CG in the clear cycle is still counted.
      if (i_clr_cnt)          o_err_cnt <= (i_valid & bad) ? ERR_CNT_W'(1) : '0;
      else if (i_valid & bad) o_err_cnt <= sat_inc(o_err_cnt);
    end
  end

endmodule

// File: tb/tb_rx_sync_monitor.sv
module tb_rx_sync_monitor;

  logic       clk;
  logic       rst, v, comma, nit, de, rdn, clr;
  logic       o_run_disp, o_sync, o_cg_err;
  logic [3:0] o_err_cnt;
  logic [2:0] o_state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] st;
    logic       sync;
    logic       cg;
    logic [3:0] err;
    logic       rd;
  } exp_t;
  exp_t q[$];

  // reference model state
  int m_state = 0, m_acq = 0, m_lvl = 0, m_good = 0, m_err = 0;
  logic m_rd = 0, m_cg = 0;

  rx_sync_monitor #(
    .COMMAS_TO_SYNC(3), .ERRS_TO_LOSE(4), .GOOD_TO_RECOVER(4), .ERR_CNT_W(4)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(v), .i_is_comma(comma),
    .i_not_in_table(nit), .i_disp_err(de), .i_run_disp_next(rdn),
    .i_clr_cnt(clr), .o_run_disp(o_run_disp), .o_sync(o_sync),
    .o_cg_err(o_cg_err), .o_err_cnt(o_err_cnt), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic r, input logic vv, input logic c,
                       input logic n, input logic d, input logic rd, input logic cl);
    logic b;
    b = n | d;
    if (r) begin
      m_state = 0; m_acq = 0; m_lvl = 0; m_good = 0; m_err = 0; m_rd = 0; m_cg = 0;
    end else begin
      m_cg = vv & b;
      if (cl)          m_err = (vv & b) ? 1 : 0;
      else if (vv & b) m_err = (m_err == 15) ? 15 : m_err + 1;
      if (vv) begin
        m_rd = rd;
        if (m_state == 0) begin
          if (c && !b) begin m_state = 1; m_acq = 1; end
        end else if (m_state == 1) begin
          m_state = (b || c) ? 0 : 2;
        end else if (m_state == 2) begin
          if (b) m_state = 0;
          else if (c) begin
            if (m_acq == 2) begin m_state = 3; m_lvl = 0; m_good = 0; end
            else begin m_state = 1; m_acq = m_acq + 1; end
          end
        end else begin
          if (b) begin
            m_good = 0;
            if (m_lvl + 1 == 4) m_state = 0;
            else m_lvl = m_lvl + 1;
          end else if (m_lvl > 0) begin
            m_good = m_good + 1;
            if (m_good == 4) begin m_lvl = m_lvl - 1; m_good = 0; end
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic vv, input logic c,
                      input logic n, input logic d, input logic rd, input logic cl);
    exp_t e, g;
    model(r, vv, c, n, d, rd, cl);
    e.st = 3'(m_state); e.sync = (m_state == 3); e.cg = m_cg;
    e.err = 4'(m_err); e.rd = m_rd;
    q.push_back(e);
    rst = r; v = vv; comma = c; nit = n; de = d; rdn = rd; clr = cl;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      g = q.pop_front();
      chk("state", 32'(o_state), 32'(g.st));
      chk("sync", 32'(o_sync), 32'(g.sync));
      chk("cg_err", 32'(o_cg_err), 32'(g.cg));
      chk("err_cnt", 32'(o_err_cnt), 32'(g.err));
      chk("run_disp", 32'(o_run_disp), 32'(g.rd));
    end
  endtask

  // r, v, comma, nit, de, rdn, clr
  task automatic do_reset();  step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic cg_comma();  step(0, 1, 1, 0, 0, 0, 0); endtask
  task automatic cg_data();   step(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic cg_bad();    step(0, 1, 0, 1, 0, 0, 0); endtask
  task automatic cg_dbad();   step(0, 1, 0, 0, 1, 0, 0); endtask
  task automatic idle();      step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic get_sync();
    for (int i = 0; i < 3; i++) begin cg_comma(); cg_data(); end
  endtask

  initial begin
    rst = 1; v = 0; comma = 0; nit = 0; de = 0; rdn = 0; clr = 0;
    do_reset(); do_reset();
    chk("reset_state", 32'(o_state), 0);
    chk("reset_sync", 32'(o_sync), 0);

    // 1: three clean comma/data pairs acquire sync right after the 3rd comma
    cg_comma(); cg_data(); cg_comma(); cg_data();
    chk("t1_not_yet", 32'(o_sync), 0);
    cg_comma();
    chk("t1_sync", 32'(o_sync), 1);
    chk("t1_err0", 32'(o_err_cnt), 0);
    cg_data();

    // 2: three bad CGs tolerated, the fourth drops sync
    cg_bad(); cg_data(); cg_dbad(); cg_data(); cg_bad(); cg_data();
    chk("t2_still_sync", 32'(o_sync), 1);
    chk("t2_err3", 32'(o_err_cnt), 3);
    cg_bad();
    chk("t2_lost", 32'(o_sync), 0);
    chk("t2_state", 32'(o_state), 0);

    // 3: one error level recovered by four good CGs, then three more bad
    do_reset();
    get_sync();
    cg_bad();
    for (int i = 0; i < 4; i++) cg_data();
    cg_bad(); cg_bad(); cg_bad();
    chk("t3_recovered", 32'(o_sync), 1);
    cg_bad();
    chk("t3_lost", 32'(o_sync), 0);

    // 4: running disparity follows strobes and holds through gaps
    do_reset();
    step(0, 1, 0, 0, 0, 1, 0);
    chk("t4_rd1", 32'(o_run_disp), 1);
    step(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
    chk("t4_hold1", 32'(o_run_disp), 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 1, 0);
    chk("t4_hold0", 32'(o_run_disp), 0);
    step(0, 1, 0, 0, 0, 1, 0);
    idle();

    // comma while in COMMA_DET falls back to LOSS_OF_SYNC
    cg_comma(); cg_comma();
    chk("cd_comma_loss", 32'(o_state), 0);

    // 5: counter saturates at all-ones; clear with a bad CG leaves 1
    do_reset();
    for (int i = 0; i < 17; i++) cg_bad();
    chk("t5_sat", 32'(o_err_cnt), 15);
    step(0, 1, 0, 1, 0, 0, 1);
    chk("t5_clr_bad", 32'(o_err_cnt), 1);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("t5_clr", 32'(o_err_cnt), 0);

    // 6: reset while in ACQUIRE with RD+
    do_reset();
    step(0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("t6_acq", 32'(o_state), 2);
    chk("t6_rd", 32'(o_run_disp), 1);
    do_reset();
    chk("t6_rst_state", 32'(o_state), 0);
    chk("t6_rst_rd", 32'(o_run_disp), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
